// File: rtl/llc_input_fetch.sv
// LLC input fetch stage: pops the decoder-selected input channel, latches the
// popped message, owns the stalled-request register, and reports each fetch
// to the process stage with a one-cycle pulse and a one-hot message type.
module llc_input_fetch #(
    parameter int RSP_W = 64,
    parameter int REQ_W = 96,
    parameter int DMA_W = 96,
    parameter int RST_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             decode_en,
    input  logic             is_rst_to_get_next,
    input  logic             is_rsp_to_get_next,
    input  logic             do_get_req,
    input  logic             do_get_dma_req,
    input  logic             update_req_in_from_stalled,
    input  logic             clr_req_in_stalled_valid,
    input  logic             set_req_stall,
    input  logic             llc_rst_tb_valid,
    output logic             llc_rst_tb_ready,
    input  logic [RST_W-1:0] llc_rst_tb_data,
    input  logic             llc_rsp_in_valid,
    output logic             llc_rsp_in_ready,
    input  logic [RSP_W-1:0] llc_rsp_in_data,
    input  logic             llc_req_in_valid,
    output logic             llc_req_in_ready,
    input  logic [REQ_W-1:0] llc_req_in_data,
    input  logic             llc_dma_req_in_valid,
    output logic             llc_dma_req_in_ready,
    input  logic [DMA_W-1:0] llc_dma_req_in_data,
    output logic [RST_W-1:0] rst_tb_in,
    output logic [RSP_W-1:0] rsp_in,
    output logic [REQ_W-1:0] req_in,
    output logic [DMA_W-1:0] dma_req_in,
    output logic             req_in_stalled_valid,
    output logic             fetch_done,
    output logic [3:0]       fetch_type,
    output logic             busy,
    output logic             proto_err
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    // Channel ids double as bit positions in the one-hot {dma, req, rsp, rst}.
    typedef enum logic [1:0] {
        CH_RST = 2'd0,
        CH_RSP = 2'd1,
        CH_REQ = 2'd2,
        CH_DMA = 2'd3
    } chan_e;

    state_e           state_q, state_d;
    chan_e            wait_ch_q, wait_ch_d;
    chan_e            sel_ch;
    logic             sel_valid;
    logic             sample;
    logic             do_update;
    logic             multi_sel;
    logic [3:0]       sel_vec;
    logic [3:0]       valid_vec;
    logic [3:0]       ready_vec;
    logic [3:0]       pop_vec;
    logic             fetch_done_d;
    logic [3:0]       fetch_type_d;

    logic [RST_W-1:0] rst_tb_q;
    logic [RSP_W-1:0] rsp_q;
    logic [REQ_W-1:0] req_q;
    logic [DMA_W-1:0] dma_q;
    logic [REQ_W-1:0] stalled_q;
    logic             stalled_valid_q;
    logic             fetch_done_q;
    logic [3:0]       fetch_type_q;
    logic             proto_err_q;

    assign sel_vec   = {do_get_dma_req, do_get_req, is_rsp_to_get_next, is_rst_to_get_next};
    assign valid_vec = {llc_dma_req_in_valid, llc_req_in_valid, llc_rsp_in_valid, llc_rst_tb_valid};

    // Decoder strobes are only meaningful while idle; WAIT ignores them entirely.
    assign sample    = (state_q == ST_IDLE) && decode_en;
    assign do_update = sample && update_req_in_from_stalled;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_sel = (sel_vec & (sel_vec - 4'd1)) != 4'd0;

    // Next-state, priority select (rst > rsp > req > dma), ready and pop generation.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d      = state_q;
        wait_ch_d    = wait_ch_q;
        sel_valid    = 1'b0;
        sel_ch       = CH_RST;
        ready_vec    = 4'b0000;

        // A resume from the stalled register replaces any channel pop this cycle.
        if (sample && !do_update) begin
            if (sel_vec[CH_RST]) begin
                sel_valid = 1'b1;
                sel_ch    = CH_RST;
            end else if (sel_vec[CH_RSP]) begin
                sel_valid = 1'b1;
                sel_ch    = CH_RSP;
            end else if (sel_vec[CH_REQ]) begin
                sel_valid = 1'b1;
                sel_ch    = CH_REQ;
            end else if (sel_vec[CH_DMA]) begin
                sel_valid = 1'b1;
                sel_ch    = CH_DMA;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    ready_vec[sel_ch] = 1'b1;
                    if (!valid_vec[sel_ch]) begin
                        state_d   = ST_WAIT;
                        wait_ch_d = sel_ch;
                    end
                end
            end
            ST_WAIT: begin
                ready_vec[wait_ch_q] = 1'b1;
                if (valid_vec[wait_ch_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pop_vec      = ready_vec & valid_vec;
        fetch_done_d = (|pop_vec) || do_update;
        fetch_type_d = do_update ? 4'b0100 : pop_vec;
    end

    // FSM state, pending channel id, fetch report and sticky protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wait_ch_q    <= CH_RST;
            fetch_done_q <= 1'b0;
            fetch_type_q <= 4'b0000;
            proto_err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            wait_ch_q    <= wait_ch_d;
            fetch_done_q <= fetch_done_d;
            fetch_type_q <= fetch_type_d;
            if (sample && multi_sel) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Holding registers: each one changes only on a pop of its own channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_tb_q <= '0;
            rsp_q    <= '0;
            req_q    <= '0;
            dma_q    <= '0;
        end else begin
            if (pop_vec[CH_RST]) rst_tb_q <= llc_rst_tb_data;
            if (pop_vec[CH_RSP]) rsp_q    <= llc_rsp_in_data;
            if (do_update) begin
                req_q <= stalled_q;
            end else if (pop_vec[CH_REQ]) begin
                req_q <= llc_req_in_data;
            end
            if (pop_vec[CH_DMA]) dma_q    <= llc_dma_req_in_data;
        end
    end

    // Stalled request: set beats clear; a simultaneous resume swaps with req_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stalled_q       <= '0;
            stalled_valid_q <= 1'b0;
        end else if (set_req_stall) begin
            stalled_q       <= req_q;
            stalled_valid_q <= 1'b1;
        end else if (clr_req_in_stalled_valid) begin
            stalled_valid_q <= 1'b0;
        end
    end

    assign llc_rst_tb_ready     = ready_vec[CH_RST];
    assign llc_rsp_in_ready     = ready_vec[CH_RSP];
    assign llc_req_in_ready     = ready_vec[CH_REQ];
    assign llc_dma_req_in_ready = ready_vec[CH_DMA];

    assign rst_tb_in            = rst_tb_q;
    assign rsp_in               = rsp_q;
    assign req_in               = req_q;
    assign dma_req_in           = dma_q;
    assign req_in_stalled_valid = stalled_valid_q;
    assign fetch_done           = fetch_done_q;
    assign fetch_type           = fetch_type_q;
    assign busy                 = (state_q == ST_WAIT);
    assign proto_err            = proto_err_q;

endmodule

// File: tb/tb_llc_input_fetch.sv
// Directed testbench for llc_input_fetch: reset, immediate and waited pops,
// stall/resume with swap, set/clear collision, back-to-back pops, multi-select.
module tb_llc_input_fetch;

    localparam int RSP_W = 64;
    localparam int REQ_W = 96;
    localparam int DMA_W = 96;
    localparam int RST_W = 1;

    logic             clk;
    logic             rst;
    logic             decode_en;
    logic             is_rst_to_get_next;
    logic             is_rsp_to_get_next;
    logic             do_get_req;
    logic             do_get_dma_req;
    logic             update_req_in_from_stalled;
    logic             clr_req_in_stalled_valid;
    logic             set_req_stall;
    logic             llc_rst_tb_valid;
    logic             llc_rst_tb_ready;
    logic [RST_W-1:0] llc_rst_tb_data;
    logic             llc_rsp_in_valid;
    logic             llc_rsp_in_ready;
    logic [RSP_W-1:0] llc_rsp_in_data;
    logic             llc_req_in_valid;
    logic             llc_req_in_ready;
    logic [REQ_W-1:0] llc_req_in_data;
    logic             llc_dma_req_in_valid;
    logic             llc_dma_req_in_ready;
    logic [DMA_W-1:0] llc_dma_req_in_data;
    logic [RST_W-1:0] rst_tb_in;
    logic [RSP_W-1:0] rsp_in;
    logic [REQ_W-1:0] req_in;
    logic [DMA_W-1:0] dma_req_in;
    logic             req_in_stalled_valid;
    logic             fetch_done;
    logic [3:0]       fetch_type;
    logic             busy;
    logic             proto_err;

    int n_cmp = 0;
    int n_err = 0;

    llc_input_fetch #(
        .RSP_W(RSP_W), .REQ_W(REQ_W), .DMA_W(DMA_W), .RST_W(RST_W)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .decode_en                  (decode_en),
        .is_rst_to_get_next         (is_rst_to_get_next),
        .is_rsp_to_get_next         (is_rsp_to_get_next),
        .do_get_req                 (do_get_req),
        .do_get_dma_req             (do_get_dma_req),
        .update_req_in_from_stalled (update_req_in_from_stalled),
        .clr_req_in_stalled_valid   (clr_req_in_stalled_valid),
        .set_req_stall              (set_req_stall),
        .llc_rst_tb_valid           (llc_rst_tb_valid),
        .llc_rst_tb_ready           (llc_rst_tb_ready),
        .llc_rst_tb_data            (llc_rst_tb_data),
        .llc_rsp_in_valid           (llc_rsp_in_valid),
        .llc_rsp_in_ready           (llc_rsp_in_ready),
        .llc_rsp_in_data            (llc_rsp_in_data),
        .llc_req_in_valid           (llc_req_in_valid),
        .llc_req_in_ready           (llc_req_in_ready),
        .llc_req_in_data            (llc_req_in_data),
        .llc_dma_req_in_valid       (llc_dma_req_in_valid),
        .llc_dma_req_in_ready       (llc_dma_req_in_ready),
        .llc_dma_req_in_data        (llc_dma_req_in_data),
        .rst_tb_in                  (rst_tb_in),
        .rsp_in                     (rsp_in),
        .req_in                     (req_in),
        .dma_req_in                 (dma_req_in),
        .req_in_stalled_valid       (req_in_stalled_valid),
        .fetch_done                 (fetch_done),
        .fetch_type                 (fetch_type),
        .busy                       (busy),
        .proto_err                  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        decode_en                  = 1'b0;
        is_rst_to_get_next         = 1'b0;
        is_rsp_to_get_next         = 1'b0;
        do_get_req                 = 1'b0;
        do_get_dma_req             = 1'b0;
        update_req_in_from_stalled = 1'b0;
        clr_req_in_stalled_valid   = 1'b0;
        set_req_stall              = 1'b0;
        llc_rst_tb_valid           = 1'b0;
        llc_rst_tb_data            = '0;
        llc_rsp_in_valid           = 1'b0;
        llc_rsp_in_data            = '0;
        llc_req_in_valid           = 1'b0;
        llc_req_in_data            = '0;
        llc_dma_req_in_valid       = 1'b0;
        llc_dma_req_in_data        = '0;
    endtask

    // Issue an immediate request-channel pop of the given value.
    task automatic pop_req(input logic [REQ_W-1:0] d);
        decode_en        = 1'b1;
        do_get_req       = 1'b1;
        llc_req_in_valid = 1'b1;
        llc_req_in_data  = d;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        llc_rst_tb_valid     = 1'b1;
        llc_rsp_in_valid     = 1'b1;
        llc_req_in_valid     = 1'b1;
        llc_dma_req_in_valid = 1'b1;
        step();
        step();
        n_cmp++; if (fetch_done !== 1'b0) begin n_err++; $display("FAIL reset_fetch_done got=%b exp=0", fetch_done); end
        n_cmp++; if (fetch_type !== 4'b0000) begin n_err++; $display("FAIL reset_fetch_type got=%b exp=0000", fetch_type); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
        n_cmp++; if (req_in_stalled_valid !== 1'b0) begin n_err++; $display("FAIL reset_stalled_valid got=%b exp=0", req_in_stalled_valid); end
        n_cmp++; if ({rst_tb_in, rsp_in, req_in, dma_req_in} !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {rst_tb_in, rsp_in, req_in, dma_req_in}); end
        n_cmp++; if ({llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready} !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", {llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready}); end
        rst = 1'b1;
        clear_inputs();
        step();
        // Valids pending with no decode strobe: nothing may be popped.
        llc_req_in_valid = 1'b1;
        llc_rsp_in_valid = 1'b1;
        #1;
        n_cmp++; if ({llc_req_in_ready, llc_rsp_in_ready} !== 2'b00) begin n_err++; $display("FAIL idle_no_decode_ready got=%b exp=00", {llc_req_in_ready, llc_rsp_in_ready}); end
        step();
        n_cmp++; if (fetch_done !== 1'b0) begin n_err++; $display("FAIL idle_no_decode_done got=%b exp=0", fetch_done); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        decode_en  = 1'b1;
        do_get_req = 1'b1;
        step();
        clear_inputs();
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midwait_busy got=%b exp=1", busy); end
        n_cmp++; if (llc_req_in_ready !== 1'b1) begin n_err++; $display("FAIL midwait_ready got=%b exp=1", llc_req_in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midwait_async_busy got=%b exp=0", busy); end
        step();
        rst = 1'b1;
        step();
        llc_req_in_valid = 1'b1;
        llc_req_in_data  = 96'hDEAD;
        #1;
        n_cmp++; if (llc_req_in_ready !== 1'b0) begin n_err++; $display("FAIL midwait_ready_after got=%b exp=0", llc_req_in_ready); end
        step();
        step();
        n_cmp++; if (req_in !== '0) begin n_err++; $display("FAIL midwait_req_in got=%h exp=0", req_in); end
        n_cmp++; if (fetch_done !== 1'b0) begin n_err++; $display("FAIL midwait_done got=%b exp=0", fetch_done); end
        clear_inputs();
    endtask

    task automatic test_immediate_pop();
        decode_en          = 1'b1;
        is_rsp_to_get_next = 1'b1;
        llc_rsp_in_valid   = 1'b1;
        llc_rsp_in_data    = 64'hA5A5;
        #1;
        n_cmp++; if ({llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready} !== 4'b0010) begin n_err++; $display("FAIL imm_ready got=%b exp=0010", {llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready}); end
        step();
        clear_inputs();
        n_cmp++; if (rsp_in !== 64'hA5A5) begin n_err++; $display("FAIL imm_rsp_in got=%h exp=a5a5", rsp_in); end
        n_cmp++; if (fetch_done !== 1'b1) begin n_err++; $display("FAIL imm_done got=%b exp=1", fetch_done); end
        n_cmp++; if (fetch_type !== 4'b0010) begin n_err++; $display("FAIL imm_type got=%b exp=0010", fetch_type); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL imm_busy got=%b exp=0", busy); end
        step();
        n_cmp++; if (fetch_done !== 1'b0) begin n_err++; $display("FAIL imm_done_pulse got=%b exp=0", fetch_done); end
    endtask

    task automatic test_wait_pop();
        decode_en      = 1'b1;
        do_get_dma_req = 1'b1;
        step();
        // In WAIT: a competing rsp select with pending valid must be ignored.
        do_get_dma_req     = 1'b0;
        is_rsp_to_get_next = 1'b1;
        llc_rsp_in_valid   = 1'b1;
        llc_rsp_in_data    = 64'hFFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wait_busy cyc=%0d got=%b exp=1", i, busy); end
            n_cmp++; if ({llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready} !== 4'b1000) begin n_err++; $display("FAIL wait_ready cyc=%0d got=%b exp=1000", i, {llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready}); end
            n_cmp++; if (fetch_done !== 1'b0) begin n_err++; $display("FAIL wait_done cyc=%0d got=%b exp=0", i, fetch_done); end
            step();
        end
        llc_dma_req_in_valid = 1'b1;
        llc_dma_req_in_data  = 96'h1234;
        #1;
        n_cmp++; if (llc_dma_req_in_ready !== 1'b1) begin n_err++; $display("FAIL wait_hs_ready got=%b exp=1", llc_dma_req_in_ready); end
        step();
        clear_inputs();
        n_cmp++; if (dma_req_in !== 96'h1234) begin n_err++; $display("FAIL wait_dma_in got=%h exp=1234", dma_req_in); end
        n_cmp++; if (fetch_done !== 1'b1) begin n_err++; $display("FAIL wait_hs_done got=%b exp=1", fetch_done); end
        n_cmp++; if (fetch_type !== 4'b1000) begin n_err++; $display("FAIL wait_hs_type got=%b exp=1000", fetch_type); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wait_hs_busy got=%b exp=0", busy); end
        n_cmp++; if (rsp_in !== 64'hA5A5) begin n_err++; $display("FAIL wait_rsp_untouched got=%h exp=a5a5", rsp_in); end
        step();
    endtask

    task automatic test_stall_resume();
        pop_req(96'h77);
        set_req_stall = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (req_in_stalled_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid got=%b exp=1", req_in_stalled_valid); end
        pop_req(96'h88);
        n_cmp++; if (req_in !== 96'h88) begin n_err++; $display("FAIL stall_new_req got=%h exp=88", req_in); end
        decode_en                  = 1'b1;
        update_req_in_from_stalled = 1'b1;
        clr_req_in_stalled_valid   = 1'b1;
        do_get_req                 = 1'b1;
        llc_req_in_valid           = 1'b1;
        llc_req_in_data            = 96'h99;
        #1;
        n_cmp++; if (llc_req_in_ready !== 1'b0) begin n_err++; $display("FAIL resume_ready got=%b exp=0", llc_req_in_ready); end
        step();
        clear_inputs();
        n_cmp++; if (req_in !== 96'h77) begin n_err++; $display("FAIL resume_req_in got=%h exp=77", req_in); end
        n_cmp++; if (req_in_stalled_valid !== 1'b0) begin n_err++; $display("FAIL resume_valid got=%b exp=0", req_in_stalled_valid); end
        n_cmp++; if ({fetch_done, fetch_type} !== 5'b10100) begin n_err++; $display("FAIL resume_done_type got=%b exp=10100", {fetch_done, fetch_type}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL resume_busy got=%b exp=0", busy); end
    endtask

    task automatic test_collision_and_swap();
        pop_req(96'h55);
        set_req_stall            = 1'b1;
        clr_req_in_stalled_valid = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (req_in_stalled_valid !== 1'b1) begin n_err++; $display("FAIL collide_valid got=%b exp=1", req_in_stalled_valid); end
        pop_req(96'h66);
        // Resume and park together: req_in and the stalled copy exchange.
        decode_en                  = 1'b1;
        update_req_in_from_stalled = 1'b1;
        set_req_stall              = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (req_in !== 96'h55) begin n_err++; $display("FAIL swap_req_in got=%h exp=55", req_in); end
        n_cmp++; if (req_in_stalled_valid !== 1'b1) begin n_err++; $display("FAIL swap_valid got=%b exp=1", req_in_stalled_valid); end
        decode_en                  = 1'b1;
        update_req_in_from_stalled = 1'b1;
        clr_req_in_stalled_valid   = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (req_in !== 96'h66) begin n_err++; $display("FAIL swap_back_req_in got=%h exp=66", req_in); end
        n_cmp++; if (req_in_stalled_valid !== 1'b0) begin n_err++; $display("FAIL swap_back_valid got=%b exp=0", req_in_stalled_valid); end
    endtask

    task automatic test_back_to_back();
        decode_en          = 1'b1;
        is_rsp_to_get_next = 1'b1;
        llc_rsp_in_valid   = 1'b1;
        llc_rsp_in_data    = 64'h11;
        step();
        n_cmp++; if ({fetch_done, fetch_type} !== 5'b10010) begin n_err++; $display("FAIL b2b_first got=%b exp=10010", {fetch_done, fetch_type}); end
        n_cmp++; if (rsp_in !== 64'h11) begin n_err++; $display("FAIL b2b_rsp_in got=%h exp=11", rsp_in); end
        is_rsp_to_get_next = 1'b0;
        llc_rsp_in_valid   = 1'b0;
        do_get_req         = 1'b1;
        llc_req_in_valid   = 1'b1;
        llc_req_in_data    = 96'h22;
        step();
        clear_inputs();
        n_cmp++; if ({fetch_done, fetch_type} !== 5'b10100) begin n_err++; $display("FAIL b2b_second got=%b exp=10100", {fetch_done, fetch_type}); end
        n_cmp++; if ({rsp_in, req_in} !== {64'h11, 96'h22}) begin n_err++; $display("FAIL b2b_data got=%h exp=%h", {rsp_in, req_in}, {64'h11, 96'h22}); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL b2b_proto_err got=%b exp=0", proto_err); end
        step();
    endtask

    task automatic test_multi_select();
        decode_en          = 1'b1;
        is_rst_to_get_next = 1'b1;
        do_get_req         = 1'b1;
        llc_rst_tb_valid   = 1'b1;
        llc_rst_tb_data    = 1'b1;
        llc_req_in_valid   = 1'b1;
        llc_req_in_data    = 96'hBAD;
        #1;
        n_cmp++; if ({llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready} !== 4'b0001) begin n_err++; $display("FAIL multi_ready got=%b exp=0001", {llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready}); end
        step();
        clear_inputs();
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL multi_proto_err got=%b exp=1", proto_err); end
        n_cmp++; if ({fetch_done, fetch_type} !== 5'b10001) begin n_err++; $display("FAIL multi_done_type got=%b exp=10001", {fetch_done, fetch_type}); end
        n_cmp++; if ({rst_tb_in, req_in} !== {1'b1, 96'h22}) begin n_err++; $display("FAIL multi_data got=%h exp=%h", {rst_tb_in, req_in}, {1'b1, 96'h22}); end
        step();
        step();
        step();
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL multi_sticky got=%b exp=1", proto_err); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL multi_reset_clear got=%b exp=0", proto_err); end
        step();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_reset_mid_wait();
        test_immediate_pop();
        test_wait_pop();
        test_stall_resume();
        test_collision_and_swap();
        test_back_to_back();
        test_multi_select();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/llc_input_fetch.md
Name: llc_input_fetch

Overview:
- Stage directly downstream of the LLC input decoder.
- Performs the ready/valid pops on the four LLC input channels (reset-tb, response, request, DMA request) that the decoder selects, and latches each popped message into a holding register.
- Owns the stalled-request register and its valid flag; the decoder consumes this flag.
- Emits a one-cycle fetch-done pulse with a one-hot message type for the LLC process stage.

Parameters:
- RSP_W, 64, packed response message width
- REQ_W, 96, packed request message width
- DMA_W, 96, packed DMA request message width
- RST_W, 1, packed reset-tb payload width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- decode_en  in  1  decoder evaluation strobe
- is_rst_to_get_next  in  1  decoder selects reset-tb pop
- is_rsp_to_get_next  in  1  decoder selects response pop
- do_get_req  in  1  decoder selects request pop
- do_get_dma_req  in  1  decoder selects DMA request pop
- update_req_in_from_stalled  in  1  load req_in from the stalled register
- clr_req_in_stalled_valid  in  1  clear the stalled flag
- set_req_stall  in  1  process stage parks the current req_in
- llc_rst_tb_valid / llc_rst_tb_ready / llc_rst_tb_data  in/out/in  1/1/RST_W
- llc_rsp_in_valid / llc_rsp_in_ready / llc_rsp_in_data  in/out/in  1/1/RSP_W
- llc_req_in_valid / llc_req_in_ready / llc_req_in_data  in/out/in  1/1/REQ_W
- llc_dma_req_in_valid / llc_dma_req_in_ready / llc_dma_req_in_data  in/out/in  1/1/DMA_W
- rst_tb_in  out  RST_W  latched reset-tb payload
- rsp_in  out  RSP_W  latched response
- req_in  out  REQ_W  latched request
- dma_req_in  out  DMA_W  latched DMA request
- req_in_stalled_valid  out  1  stalled request present
- fetch_done  out  1  one-cycle pulse: a message was latched last cycle
- fetch_type  out  4  one-hot {dma, req, rsp, rst}; valid with fetch_done
- busy  out  1  FSM not in IDLE
- proto_err  out  1  sticky: two or more selects asserted together

Behaviour:
- Reset: all data registers 0, req_in_stalled_valid 0, fetch_done 0, fetch_type 0, busy 0, proto_err 0, all ready outputs 0, FSM IDLE. Reset is honoured mid-fetch; any pending pop is abandoned.
- Select: sel = the decoder strobes, sampled only when decode_en=1 and the FSM is IDLE.
  - In IDLE, decode_en=0 means no pop.
  - If more than one select is set, proto_err is set and priority applies: rst > rsp > req > dma.
- update_req_in_from_stalled (with decode_en):
  - req_in <= stalled register next cycle.
  - fetch_done pulses next cycle with fetch_type=0100.
  - No channel pop occurs.
- FSM states: IDLE, WAIT.
  - IDLE: for the selected channel, ready is driven combinationally equal to the select.
    - If that channel's valid=1 in the same cycle, the data is latched at the clock edge, fetch_done=1 and fetch_type is set the next cycle, and the FSM stays IDLE.
    - If valid=0, the channel id is registered and the FSM goes to WAIT.
  - WAIT: ready for the registered channel is held at 1; ignore decode_en and all selects.
    - On the valid=1 cycle, latch the data, return to IDLE, and pulse fetch_done the next cycle.
    - busy=1 throughout WAIT.
- Latency: pop to fetch_done is exactly 1 cycle. Back-to-back pops are allowed every cycle from IDLE.
- Ready is never asserted on an unselected channel. A valid arriving on an unselected channel is left pending untouched.
- Stalled register:
  - set_req_stall=1: stalled <= req_in, req_in_stalled_valid <= 1.
  - clr_req_in_stalled_valid=1: req_in_stalled_valid <= 0.
  - Set and clear in the same cycle: set wins (valid=1, stalled = current req_in).
  - update plus set in the same cycle: stalled captures the old req_in, and req_in loads the old stalled contents (swap).
- A latched register holds its value until the next pop of its own channel. Other channels do not disturb it.

Test Plan:
- Reset mid-WAIT: select req with llc_req_in_valid=0, assert rst low 1 cycle, valid=1 later -> ready stays 0, no latch, busy 0, req_in=0.
- Immediate pop: decode_en=1, is_rsp_to_get_next=1, rsp_valid=1, data=0xA5A5 -> rsp_ready=1 same cycle; next cycle rsp_in=0xA5A5, fetch_done=1, fetch_type=0010.
- Wait pop: do_get_dma_req=1 with dma_valid=0 for 3 cycles, then valid=1 with data=0x1234 -> busy=1 for 3 cycles; dma_ready held; dma_req_in=0x1234; fetch_done 1 cycle after the handshake; no other channel popped during WAIT.
- Stall/resume: req_in=0x77, set_req_stall -> req_in_stalled_valid=1. Pop new req 0x88. Then update+clr -> req_in=0x77, valid=0, fetch_type=0100, req channel not popped.
- Set/clr collision: set_req_stall and clr_req_in_stalled_valid in the same cycle -> valid=1.
- Multi-select: is_rst_to_get_next and do_get_req both 1 -> only rst_ready=1; proto_err=1 and sticky until reset.
